// File: rtl/ysyx_22050550_lsu_pkg.sv
// Shared definitions for the LSU stage: funct3 size codes, FSM states,
// exception codes and the byte-mask / misalignment helpers.
package ysyx_22050550_lsu_pkg;

  localparam int LSU_XLEN = 64;
  localparam int LSU_AW   = 64;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUS      = 2'b10;

  // Low two funct3 bits give the access width; bit 2 only selects zero-extension.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    logic [7:0] m;
    case (size[1:0])
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] off);
    logic mis;
    case (size)
      SZ_H, SZ_HU: mis = off[0];
      SZ_W, SZ_WU: mis = |off[1:0];
      SZ_D:        mis = |off;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_22050550_lsu_align.sv
// Combinational data path of the LSU: store lane placement and strobes,
// misalignment detection, and load extraction with sign/zero extension.
module ysyx_22050550_lsu_align
  import ysyx_22050550_lsu_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int MASK_W = XLEN / 8
) (
  input  logic [2:0]        i_st_size,
  input  logic [2:0]        i_st_off,
  input  logic [XLEN-1:0]   i_st_data,
  output logic [XLEN-1:0]   o_st_wdata,
  output logic [MASK_W-1:0] o_st_wmask,
  output logic              o_misalign,
  input  logic [2:0]        i_ld_size,
  input  logic [2:0]        i_ld_off,
  input  logic [XLEN-1:0]   i_ld_rdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [XLEN-1:0] w_ld_shifted;

  assign o_st_wdata = i_st_data << {i_st_off, 3'b000};
  assign o_st_wmask = MASK_W'(size_mask(i_st_size)) << i_st_off;
  assign o_misalign = is_misaligned(i_st_size, i_st_off);

  assign w_ld_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

  // D (and the unused 111 code) takes the whole shifted word unchanged.
  always_comb begin
    o_ld_data = w_ld_shifted;
    case (i_ld_size)
      SZ_B:  o_ld_data = {{(XLEN-8){w_ld_shifted[7]}},   w_ld_shifted[7:0]};
      SZ_H:  o_ld_data = {{(XLEN-16){w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      SZ_W:  o_ld_data = {{(XLEN-32){w_ld_shifted[31]}}, w_ld_shifted[31:0]};
      SZ_BU: o_ld_data = {{(XLEN-8){1'b0}},  w_ld_shifted[7:0]};
      SZ_HU: o_ld_data = {{(XLEN-16){1'b0}}, w_ld_shifted[15:0]};
      SZ_WU: o_ld_data = {{(XLEN-32){1'b0}}, w_ld_shifted[31:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_22050550_lsu.sv
// LSU stage between EXU and regfile: one memory transaction per instruction
// over a req/resp bus, registered writeback bundle, flush/kill handling.
module ysyx_22050550_lsu
  import ysyx_22050550_lsu_pkg::*;
#(
  parameter int XLEN   = LSU_XLEN,
  parameter int AW     = LSU_AW,
  parameter int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [2:0]        in_size,
  input  logic [AW-1:0]     in_addr,
  input  logic [XLEN-1:0]   in_sdata,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [AW-1:0]     mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [XLEN-1:0]   out_wdata,
  output logic [1:0]        out_exc
);

  lsu_state_t r_state, w_next;
  logic              r_kill;
  logic              r_wr;
  logic [2:0]        r_size;
  logic [2:0]        r_off;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic              r_out_valid;
  logic [4:0]        r_out_rd;
  logic              r_out_wen;
  logic [XLEN-1:0]   r_out_wdata;
  logic [1:0]        r_out_exc;

  logic              w_accept, w_is_mem, w_misalign, w_req, w_resp;
  logic [XLEN-1:0]   w_st_wdata, w_ld_data;
  logic [MASK_W-1:0] w_st_wmask;

  assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_is_mem = in_mem_rd || in_mem_wr;
  assign w_req    = (r_state == ST_REQ);
  assign w_resp   = (r_state == ST_WAIT) && mem_resp_valid;

  ysyx_22050550_lsu_align #(.XLEN(XLEN), .MASK_W(MASK_W)) u_align (
    .i_st_size  (in_size),
    .i_st_off   (in_addr[2:0]),
    .i_st_data  (in_sdata),
    .o_st_wdata (w_st_wdata),
    .o_st_wmask (w_st_wmask),
    .o_misalign (w_misalign),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_rdata (mem_resp_data),
    .o_ld_data  (w_ld_data)
  );

  // Request fields are zeroed outside REQ so the bus never sees stale data.
  assign mem_req_valid = w_req;
  assign mem_req_wr    = w_req && r_wr;
  assign mem_req_addr  = w_req ? r_addr  : '0;
  assign mem_req_wdata = w_req ? r_wdata : '0;
  assign mem_req_wmask = w_req ? r_wmask : '0;

  assign out_valid = r_out_valid;
  assign out_rd    = r_out_rd;
  assign out_wen   = r_out_wen;
  assign out_wdata = r_out_wdata;
  assign out_exc   = r_out_exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mem && !w_misalign) w_next = ST_REQ;
      ST_REQ:  if (mem_req_ready)                       w_next = ST_WAIT;
      ST_WAIT: if (mem_resp_valid)                      w_next = ST_IDLE;
      default:                                          w_next = ST_IDLE;
    endcase
  end

  // A flushed in-flight access still finishes on the bus; kill only hides its result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_kill <= 1'b0;
    else if (w_resp)                         r_kill <= 1'b0;
    else if (flush && r_state != ST_IDLE)    r_kill <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rd    <= '0;
      r_wen   <= 1'b0;
    end else if (w_accept && w_is_mem) begin
      r_wr    <= in_mem_wr;
      r_size  <= in_size;
      r_off   <= in_addr[2:0];
      r_addr  <= {in_addr[AW-1:3], 3'b000};
      r_wdata <= w_st_wdata;
      r_wmask <= w_st_wmask;
      r_rd    <= in_rd;
      r_wen   <= in_wen;
    end
  end

  // Writeback register: pops on out_ready, reloads on pass-through, misalign or response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_wen   <= 1'b0;
      r_out_wdata <= '0;
      r_out_exc   <= EXC_NONE;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept && !w_is_mem) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= in_rd;
        r_out_wen   <= in_wen;
        r_out_wdata <= in_alu;
        r_out_exc   <= EXC_NONE;
      end else if (w_accept && w_misalign) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= in_rd;
        r_out_wen   <= 1'b0;
        r_out_wdata <= '0;
        r_out_exc   <= EXC_MISALIGN;
      end else if (w_resp && !r_kill) begin
        r_out_valid <= 1'b1;
        r_out_rd    <= r_rd;
        r_out_wen   <= r_wen && !r_wr && !mem_resp_err;
        r_out_wdata <= (r_wr || mem_resp_err) ? '0 : w_ld_data;
        r_out_exc   <= mem_resp_err ? EXC_BUS : EXC_NONE;
      end
    end
  end

endmodule
